stream_mux_rr: RTL and testbench

- Parametrised N-channel streaming multiplexer with valid/ready handshakes.
- Successor to the combinational 2/4/8:1 muxes in the mux library.
- Arbitrates among CHANNELS input streams using either fixed-priority or round-robin selection.
- Locks onto a channel for the duration of a packet (delimited by last) and drives one registered output stage that carries the source channel index.
- Sits between multiple producers and a single shared consumer bus.

---
 rtl/stream_mux_rr.sv | 103 ++++++++++
 tb/tb_stream_mux_rr.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-priority or round-robin
// arbitration, packet locking on last, and a single registered output stage.
module stream_mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode_rr,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_reg;
  logic [SEL_W-1:0] lock_ch_reg;
  logic [SEL_W-1:0] ptr_reg;

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic [SEL_W-1:0] rr_idx  [CHANNELS];
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr_next;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;

  // rr_idx[k] is the channel examined k places after the round-robin pointer
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign rr_idx[gi]   = SEL_W'((int'(ptr_reg) + gi) % CHANNELS);
      assign in_ready[gi] = xfer && (grant == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (state_reg == LOCKED) begin
      grant       = lock_ch_reg;
      grant_valid = in_valid[lock_ch_reg];
    end else if (mode_rr) begin
      // Descending scan so the candidate closest to the pointer wins
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (in_valid[rr_idx[k]]) begin
          grant       = rr_idx[k];
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (in_valid[k]) begin
          grant       = SEL_W'(k);
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign xfer     = !rst && load_en && grant_valid;
  assign ptr_next = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      lock_ch_reg <= '0;
      ptr_reg     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_sel     <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[grant];
        out_last  <= in_last[grant];
        out_sel   <= grant;
        if (state_reg == IDLE) begin
          ptr_reg <= ptr_next;
          if (!in_last[grant]) begin
            state_reg   <= LOCKED;
            lock_ch_reg <= grant;
          end
        end else if (in_last[grant]) begin
          state_reg <= IDLE;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed scenarios plus a randomized run against a packet-level arbitration
// model of stream_mux_rr.
module tb_stream_mux_rr;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode_rr;
  logic [WIDTH-1:0]          out_data;
  logic                      out_last;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      out_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit               m_locked = 0;
  int               m_lock_ch = 0;
  int               m_ptr = 0;
  bit               m_ov = 0;
  bit               m_ol = 0;
  logic [WIDTH-1:0] m_od = '0;
  int               m_os = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .mode_rr(mode_rr),
    .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic int m_grant();
    int c;
    if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < CHANNELS; k++) begin
      c = mode_rr ? (m_ptr + k) % CHANNELS : k;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [CHANNELS-1:0] m_ready();
    logic [CHANNELS-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (!rst && (!m_ov || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_ch(input int c, input bit v, input bit l, input logic [WIDTH-1:0] d);
    in_valid[c] = v;
    in_last[c]  = l;
    in_data[c*WIDTH +: WIDTH] = d;
  endtask

  task automatic clear_all();
    for (int c = 0; c < CHANNELS; c++) set_ch(c, 0, 0, '0);
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    int g;
    bit ld;
    g  = m_grant();
    ld = !m_ov || out_ready;
    @(posedge clk);
    if (rst) begin
      m_locked = 0; m_lock_ch = 0; m_ptr = 0;
      m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
    end else if (ld && g >= 0) begin
      m_ov = 1;
      m_od = in_data[g*WIDTH +: WIDTH];
      m_ol = in_last[g];
      m_os = g;
      $display("t=%0t xfer ch=%0d data=%h last=%0d", $time, g, m_od, m_ol);
      if (!m_locked) begin
        m_ptr     = (g + 1) % CHANNELS;
        m_locked  = !in_last[g];
        m_lock_ch = g;
      end else if (in_last[g]) begin
        m_locked = 0;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; mode_rr = 0; out_ready = 1;
    for (int c = 0; c < CHANNELS; c++) set_ch(c, 1, 1, WIDTH'(16'hA000 + c));
    repeat (2) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || out_sel !== 2'd0) begin n_err++; $display("FAIL reset_out: valid=%b sel=%0d want 0/0", out_valid, out_sel); end
    end
    rst = 0;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 16'hA000) begin n_err++; $display("FAIL reset_first_beat: v=%b sel=%0d data=%h want 1/0/a000", out_valid, out_sel, out_data); end
  endtask

  task automatic test_fixed_priority();
    mode_rr = 0; out_ready = 1;
    clear_all();
    set_ch(1, 1, 1, 16'h1111);
    set_ch(3, 1, 1, 16'h3333);
    repeat (6) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL fp_in_ready: got %b want 0010", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 16'h1111) begin n_err++; $display("FAIL fp_out: v=%b sel=%0d data=%h want 1/1/1111", out_valid, out_sel, out_data); end
    end
  endtask

  task automatic test_round_robin();
    logic [CHANNELS-1:0] exp_r;
    rst = 1; tick(); rst = 0;
    mode_rr = 1; out_ready = 1;
    for (int c = 0; c < CHANNELS; c++) set_ch(c, 1, 1, WIDTH'(16'hA000 + c));
    for (int k = 0; k < 12; k++) begin
      exp_r = '0;
      exp_r[k % CHANNELS] = 1'b1;
      #1;
      n_cmp++; if (in_ready !== exp_r) begin n_err++; $display("FAIL rr_in_ready: beat %0d got %b want %b", k, in_ready, exp_r); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== SEL_W'(k % CHANNELS) || out_data !== WIDTH'(16'hA000 + k % CHANNELS))
        begin n_err++; $display("FAIL rr_out: beat %0d v=%b sel=%0d data=%h want sel %0d", k, out_valid, out_sel, out_data, k % CHANNELS); end
    end
  endtask

  task automatic test_packet_lock();
    mode_rr = 0; out_ready = 1;
    clear_all();
    set_ch(2, 1, 0, 16'h0201);
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL lock_b1_ready: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_data !== 16'h0201 || out_sel !== 2'd2) begin n_err++; $display("FAIL lock_b1_out: data=%h sel=%0d want 0201/2", out_data, out_sel); end
    set_ch(0, 1, 1, 16'h00C0);
    set_ch(2, 1, 0, 16'h0202);
    mode_rr = 1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL lock_b2_ready: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_data !== 16'h0202 || out_last !== 1'b0) begin n_err++; $display("FAIL lock_b2_out: data=%h last=%b want 0202/0", out_data, out_last); end
    set_ch(2, 0, 0, 16'h0000);
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL lock_bubble_ready: got %b want 0000", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lock_bubble_out: valid=%b want 0", out_valid); end
    set_ch(2, 1, 1, 16'h0203);
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL lock_b3_ready: got %b want 0100", in_ready); end
    tick();
    n_cmp++; if (out_data !== 16'h0203 || out_last !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL lock_b3_out: data=%h last=%b v=%b want 0203/1/1", out_data, out_last, out_valid); end
    set_ch(2, 0, 0, 16'h0000);
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL lock_release_ready: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_sel !== 2'd0 || out_data !== 16'h00C0) begin n_err++; $display("FAIL lock_release_out: sel=%0d data=%h want 0/00c0", out_sel, out_data); end
  endtask

  task automatic test_backpressure();
    mode_rr = 0; out_ready = 1;
    clear_all();
    set_ch(1, 1, 1, 16'hBEEF);
    #1;
    tick();
    n_cmp++; if (out_data !== 16'hBEEF || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_load: data=%h v=%b want beef/1", out_data, out_valid); end
    set_ch(1, 0, 0, 16'h0000);
    set_ch(0, 1, 1, 16'h1234);
    out_ready = 0;
    repeat (5) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready: got %b want 0000", in_ready); end
      tick();
      n_cmp++; if ({out_valid, out_last, out_sel, out_data} !== {1'b1, 1'b1, 2'd1, 16'hBEEF})
        begin n_err++; $display("FAIL bp_hold: v=%b last=%b sel=%0d data=%h want 1/1/1/beef", out_valid, out_last, out_sel, out_data); end
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL bp_release_ready: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 16'h1234) begin n_err++; $display("FAIL bp_release_out: v=%b sel=%0d data=%h want 1/0/1234", out_valid, out_sel, out_data); end
  endtask

  task automatic test_mid_packet_reset();
    mode_rr = 0; out_ready = 1;
    clear_all();
    set_ch(1, 1, 0, 16'h0101);
    #1;
    tick();
    n_cmp++; if (out_sel !== 2'd1 || out_data !== 16'h0101) begin n_err++; $display("FAIL mpr_beat1: sel=%0d data=%h want 1/0101", out_sel, out_data); end
    set_ch(0, 1, 1, 16'h00AA);
    set_ch(1, 1, 0, 16'h0102);
    rst = 1;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL mpr_rst_ready: got %b want 0000", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 16'h0000) begin n_err++; $display("FAIL mpr_rst_out: v=%b sel=%0d data=%h want 0/0/0000", out_valid, out_sel, out_data); end
    rst = 0;
    mode_rr = 1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL mpr_regrant: got %b want 0001", in_ready); end
    tick();
    n_cmp++; if (out_sel !== 2'd0 || out_data !== 16'h00AA) begin n_err++; $display("FAIL mpr_regrant_out: sel=%0d data=%h want 0/00aa", out_sel, out_data); end
  endtask

  task automatic test_random();
    logic [CHANNELS-1:0] exp_r;
    rst = 1; #1; tick(); rst = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int c = 0; c < CHANNELS; c++)
        set_ch(c, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, WIDTH'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) mode_rr = ~mode_rr;
      rst = $urandom_range(0, 99) == 0;
      #1;
      exp_r = m_ready();
      n_cmp++; if (in_ready !== exp_r) begin n_err++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", cyc, in_ready, exp_r); end
      n_cmp++; if ($countones(in_ready) > 1) begin n_err++; $display("FAIL rand_onehot: cycle %0d got %b want at most one bit", cyc, in_ready); end
      tick();
      n_cmp++; if ({out_valid, out_last, out_sel, out_data} !== {m_ov, m_ol, SEL_W'(m_os), m_od})
        begin n_err++; $display("FAIL rand_out: cycle %0d got v=%b l=%b s=%0d d=%h want v=%b l=%b s=%0d d=%h",
                                cyc, out_valid, out_last, out_sel, out_data, m_ov, m_ol, m_os, m_od); end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; mode_rr = 0; out_ready = 1;
    in_valid = '0; in_last = '0; in_data = '0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_mid_packet_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
